// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized osc_in rising edges over a gated window.
// Define RO_FREQ_OVF_EN to make count saturate and to add the sticky overflow output.
module ro_freq_counter #(
   parameter int GATE_W = 16,
   parameter int CNT_W  = 16,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              osc_in,
   output logic              osc_en,
   output logic              busy,
   output logic              valid,
   output logic [CNT_W-1:0]  count
`ifdef RO_FREQ_OVF_EN
   ,
   output logic              overflow
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t            state, state_nxt;
   logic              osc_p0, osc_p1, osc_p2;
   logic              rise_p2;
   logic              start_acc;
   logic [3:0]        settle_cnt;
   logic [GATE_W-1:0] gate_lat;
   logic [GATE_W-1:0] gate_cnt;

`ifdef RO_FREQ_OVF_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c) return c;
      return c + CNT_W'(1);
   endfunction
`endif

   // Stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         osc_p0 <= 1'b0;
         osc_p1 <= 1'b0;
         osc_p2 <= 1'b0;
      end else begin
         osc_p0 <= osc_in;
         osc_p1 <= osc_p0;
         osc_p2 <= osc_p1;
      end
   end

   assign rise_p2   = osc_p1 & ~osc_p2;
   assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
         S_SETTLE: begin
            if (settle_cnt == 4'd0)
               state_nxt = (gate_lat == '0) ? S_DONE : S_MEASURE;
         end
         S_MEASURE: if (gate_cnt == '0) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so osc_en never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         osc_en <= 1'b0;
         busy   <= 1'b0;
         valid  <= 1'b0;
      end else begin
         osc_en <= (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE);
         busy   <= (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE);
         valid  <= (state_nxt == S_DONE);
      end
   end

   // gate_cnt holds the remaining MEASURE cycles minus one; unused when gate_lat is zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_lat   <= '0;
         gate_cnt   <= '0;
         settle_cnt <= 4'd0;
         count      <= '0;
`ifdef RO_FREQ_OVF_EN
         overflow   <= 1'b0;
`endif
      end else if (start_acc) begin
         gate_lat   <= gate_cycles;
         gate_cnt   <= gate_cycles - GATE_W'(1);
         settle_cnt <= SETTLE_LAST;
         count      <= '0;
`ifdef RO_FREQ_OVF_EN
         overflow   <= 1'b0;
`endif
      end else begin
         if ((state == S_SETTLE) && (settle_cnt != 4'd0))
            settle_cnt <= settle_cnt - 4'd1;
         if (state == S_MEASURE) begin
            if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_W'(1);
            if (rise_p2) begin
`ifdef RO_FREQ_OVF_EN
               if (&count) overflow <= 1'b1;
               count <= sat_inc(count);
`else
               count <= count + CNT_W'(1);
`endif
            end
         end
      end
   end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 The block SHALL have parameter GATE_W, default 16, meaning the width of the gate-window length input.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the edge-count result.
REQ-003 The block SHALL have parameter SETTLE, default 4, meaning the number of clk cycles the oscillator runs, uncounted, before measurement starts; legal range 3..15.
REQ-004 Port clk: input, 1 bit, the single system clock. All logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n: input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port start: input, 1 bit, single-cycle measurement request.
REQ-007 Port gate_cycles: input, GATE_W bits, measurement window length in clk cycles; sampled with start.
REQ-008 Port osc_in: input, 1 bit, ring-oscillator output (or its divided output), asynchronous to clk.
REQ-009 Port osc_en: output, 1 bit, enable to the ring-oscillator NAND stage.
REQ-010 Port busy: output, 1 bit, high while a measurement is in progress.
REQ-011 Port valid: output, 1 bit, high while count holds a completed result.
REQ-012 Port count: output, CNT_W bits, number of osc_in rising edges counted in the last window.
REQ-013 Port overflow: output, 1 bit, present only when RO_FREQ_OVF_EN is defined.

Function
REQ-014 osc_in SHALL pass through a 2-flop synchronizer and then a third register; a rising-edge pulse SHALL be (sync2 & ~sync3).
REQ-015 The FSM SHALL have states IDLE, SETTLE, MEASURE, and DONE, with reset state IDLE.
REQ-016 In IDLE or DONE, start=1 SHALL latch gate_cycles, clear count (and overflow), deassert valid, and enter SETTLE on the next cycle.
REQ-017 start SHALL be ignored in SETTLE and MEASURE; no restart and no latch update occur.
REQ-018 SETTLE SHALL last exactly SETTLE cycles with osc_en=1, busy=1, and edges not counted, then enter MEASURE.
REQ-019 MEASURE SHALL last exactly the latched gate_cycles cycles; each cycle with an edge pulse SHALL increment count by 1.
REQ-020 A latched gate_cycles of 0 SHALL skip MEASURE (SETTLE goes directly to DONE) with count=0.
REQ-021 DONE SHALL drive osc_en=0, busy=0, and valid=1, and SHALL hold count until the next accepted start.
REQ-022 Latency: with start sampled in cycle 0, SETTLE occupies cycles 1..SETTLE, MEASURE occupies SETTLE+1..SETTLE+G, and valid rises in cycle SETTLE+G+1.
REQ-023 Inputs are only guaranteed to count exactly when the osc_in frequency is below clk/2; faster inputs SHALL NOT corrupt the FSM.
REQ-024 osc_en SHALL be driven by a register, never combinationally.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with osc_en=0, busy=0, valid=0, count=0, overflow=0, all synchronizer flops at 0, and the latched gate=0.
REQ-026 Reset asserted mid-measurement SHALL abort immediately; after release the block waits in IDLE and produces no stale valid.

Configuration
REQ-027 With RO_FREQ_OVF_EN defined, count SHALL saturate at 2^CNT_W-1, and overflow SHALL set on the first increment attempted at saturation and hold until the next accepted start.
REQ-028 Without RO_FREQ_OVF_EN, count SHALL wrap modulo 2^CNT_W, and the overflow port and its logic SHALL be absent.

Verification
REQ-029 Reset: rst_n low with osc_in toggling -> osc_en=0, busy=0, valid=0, count=0 throughout.
REQ-030 Nominal: osc_in period 4 clk, gate_cycles=100, SETTLE=4 -> valid rises 105 cycles after start; count=25 (±1); osc_en high during cycles 1..104.
REQ-031 Stuck oscillator: osc_in held 0, gate_cycles=50 -> count=0, valid=1 at cycle 55.
REQ-032 Zero gate and ignored restart: gate_cycles=0 -> valid at cycle 5 with count=0; start pulsed at cycle 2 of a separate run -> no effect, original timing kept.
REQ-033 Overflow: CNT_W=4, osc_in period 2 clk, gate_cycles=64 -> with macro count=15 and overflow=1; without macro count=0 (32 mod 16).
REQ-034 Mid-run reset: rst_n pulsed low at cycle 20 of a 100-cycle gate -> all outputs 0 immediately; no valid until a new start.
